cpu6_bus_cycle: RTL and testbench



---
 rtl/cpu6_bus_cycle.sv | 156 +++++++++++++++
 tb/tb_cpu6_bus_cycle.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cpu6_bus_cycle.sv
// External memory bus cycle controller for the CPU6 datapath: address setup, strobe,
// programmable wait states and a ready handshake with timeout, one request at a time.
module cpu6_bus_cycle #(
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        bus_error,
    output logic [7:0]  rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_doe,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_din,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {IDLE, ADDR, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [7:0] TMO_INIT  = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        timed_out;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bus_error_q, bus_error_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_doe_q, mem_doe_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        strobe_d;

    // Every output is a flop, so a reset mid-cycle drops the strobes without a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            wait_q      <= 4'd0;
            tmo_q       <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bus_error_q <= 1'b0;
            rdata_q     <= 8'h00;
            mem_addr_q  <= 16'h0000;
            mem_dout_q  <= 8'h00;
            mem_doe_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            wait_q      <= wait_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bus_error_q <= bus_error_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
            mem_doe_q   <= mem_doe_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        wait_d    = wait_q;
        tmo_d     = tmo_q;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ADDR;
                    we_d    = we;
                end
            end
            ADDR: begin
                wait_d  = WAIT_INIT;
                state_d = STROBE;
            end
            STROBE: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    tmo_d   = TMO_INIT;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (mem_ready) begin
                    state_d = DONE;
                end else if (tmo_q > 8'd1) begin
                    tmo_d = tmo_q - 8'd1;
                end else begin
                    state_d   = DONE;
                    timed_out = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        bus_error_d = timed_out;
        strobe_d    = (state_d == STROBE) || (state_d == HOLD);
        mem_rd_d    = strobe_d & ~we_d;
        mem_wr_d    = strobe_d & we_d;
        mem_doe_d   = (state_d != IDLE) & we_d;
        mem_addr_d  = mem_addr_q;
        mem_dout_d  = mem_dout_q;
        rdata_d     = rdata_q;
        if (state_q == IDLE && req) begin
            mem_addr_d = addr;
            mem_dout_d = wdata;
        end
        if (state_q == HOLD && !we_q) begin
            if (mem_ready) begin
                rdata_d = mem_din;
            end else if (timed_out) begin
                rdata_d = 8'hFF;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bus_error = bus_error_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_dout  = mem_dout_q;
    assign mem_doe   = mem_doe_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_cpu6_bus_cycle.sv
// Directed bench for cpu6_bus_cycle: instance A has no wait states and the default timeout,
// instance B has three wait states and a four-cycle timeout.
module tb_cpu6_bus_cycle;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic        a_req = 1'b0, a_we = 1'b0, a_mem_ready = 1'b0;
    logic [15:0] a_addr = 16'h0000;
    logic [7:0]  a_wdata = 8'h00, a_mem_din = 8'h00;
    logic        a_busy, a_done, a_bus_error, a_mem_doe, a_mem_rd, a_mem_wr;
    logic [7:0]  a_rdata, a_mem_dout;
    logic [15:0] a_mem_addr;

    logic        b_req = 1'b0, b_we = 1'b0, b_mem_ready = 1'b0;
    logic [15:0] b_addr = 16'h0000;
    logic [7:0]  b_wdata = 8'h00, b_mem_din = 8'h00;
    logic        b_busy, b_done, b_bus_error, b_mem_doe, b_mem_rd, b_mem_wr;
    logic [7:0]  b_rdata, b_mem_dout;
    logic [15:0] b_mem_addr;

    int checks = 0;
    int errors = 0;

    logic [15:0] rd_v, wr_v, doe_v, done_v, busy_v, berr_v;
    logic [15:0] addr_log [16];
    logic [7:0]  dout_log [16];
    logic [7:0]  rdata_log [16];
    logic        overlap = 1'b0;

    always #5 clock = ~clock;

    cpu6_bus_cycle #(.WAIT_STATES(0), .TIMEOUT(255)) dut_a (
        .clock(clock), .reset(reset), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
        .busy(a_busy), .done(a_done), .bus_error(a_bus_error), .rdata(a_rdata),
        .mem_addr(a_mem_addr), .mem_dout(a_mem_dout), .mem_doe(a_mem_doe),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_din(a_mem_din), .mem_ready(a_mem_ready)
    );

    cpu6_bus_cycle #(.WAIT_STATES(3), .TIMEOUT(4)) dut_b (
        .clock(clock), .reset(reset), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
        .busy(b_busy), .done(b_done), .bus_error(b_bus_error), .rdata(b_rdata),
        .mem_addr(b_mem_addr), .mem_dout(b_mem_dout), .mem_doe(b_mem_doe),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_din(b_mem_din), .mem_ready(b_mem_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit i of each vector records the output during cycle i after the accepting edge.
    task automatic applyStimulus(input int n, input bit use_b, input int ready_at,
                                 input int drop_at, input int swap_at);
        rd_v = '0; wr_v = '0; doe_v = '0; done_v = '0; busy_v = '0; berr_v = '0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clock);
            #1;
            rd_v[i]      = use_b ? b_mem_rd    : a_mem_rd;
            wr_v[i]      = use_b ? b_mem_wr    : a_mem_wr;
            doe_v[i]     = use_b ? b_mem_doe   : a_mem_doe;
            done_v[i]    = use_b ? b_done      : a_done;
            busy_v[i]    = use_b ? b_busy      : a_busy;
            berr_v[i]    = use_b ? b_bus_error : a_bus_error;
            addr_log[i]  = use_b ? b_mem_addr  : a_mem_addr;
            dout_log[i]  = use_b ? b_mem_dout  : a_mem_dout;
            rdata_log[i] = use_b ? b_rdata     : a_rdata;
            if ((a_mem_rd && a_mem_wr) || (b_mem_rd && b_mem_wr)) overlap = 1'b1;
            if (i == ready_at) begin a_mem_ready = 1'b1; b_mem_ready = 1'b1; end
            if (i == drop_at)  begin a_req = 1'b0; b_req = 1'b0; end
            if (i == swap_at) begin
                a_we = 1'b0; a_addr = 16'h0200; a_wdata = 8'h22; a_mem_din = 8'h77;
            end
        end
    endtask

    initial begin
        #1;
        checkOutput("reset_a_flags", {a_busy, a_done, a_bus_error, a_mem_rd, a_mem_wr, a_mem_doe}, 0);
        checkOutput("reset_b_flags", {b_busy, b_done, b_bus_error, b_mem_rd, b_mem_wr, b_mem_doe}, 0);
        checkOutput("reset_a_regs", {a_mem_addr, a_mem_dout, a_rdata}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h1234; a_mem_din = 8'hA5; a_mem_ready = 1'b1;
        applyStimulus(6, 1'b0, 0, 1, 0);
        checkOutput("rd0_rd", rd_v, 16'h000C);
        checkOutput("rd0_done", done_v, 16'h0010);
        checkOutput("rd0_busy", busy_v, 16'h001E);
        checkOutput("rd0_berr_wr", {berr_v, wr_v}, 32'h0);
        checkOutput("rd0_rdata", a_rdata, 8'hA5);
        checkOutput("rd0_addr_kept", a_mem_addr, 16'h1234);

        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h2000; a_mem_din = 8'h42; a_mem_ready = 1'b0;
        applyStimulus(12, 1'b0, 9, 1, 0);
        checkOutput("slow_rd", rd_v, 16'h03FC);
        checkOutput("slow_done", done_v, 16'h0400);
        checkOutput("slow_berr", berr_v, 16'h0000);
        checkOutput("slow_rdata", a_rdata, 8'h42);

        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0100; a_wdata = 8'h11; a_mem_ready = 1'b1;
        applyStimulus(11, 1'b0, 0, 6, 1);
        checkOutput("b2b_done", done_v, 16'h0210);
        checkOutput("b2b_busy", busy_v, 16'h03DE);
        checkOutput("b2b_wr", wr_v, 16'h000C);
        checkOutput("b2b_rd", rd_v, 16'h0180);
        checkOutput("b2b_doe", doe_v, 16'h001E);
        checkOutput("b2b_addr1", addr_log[3], 16'h0100);
        checkOutput("b2b_dout1", dout_log[3], 8'h11);
        checkOutput("b2b_rdata_wr", rdata_log[4], 8'h42);
        checkOutput("b2b_addr2", addr_log[6], 16'h0200);
        checkOutput("b2b_rdata", a_rdata, 8'h77);

        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0042; b_mem_din = 8'h99; b_mem_ready = 1'b0;
        applyStimulus(12, 1'b1, 0, 1, 0);
        checkOutput("tmo_rd", rd_v, 16'h03FC);
        checkOutput("tmo_done", done_v, 16'h0400);
        checkOutput("tmo_berr", berr_v, 16'h0400);
        checkOutput("tmo_wr", wr_v, 16'h0000);
        checkOutput("tmo_rdata", b_rdata, 8'hFF);

        b_req = 1'b1; b_we = 1'b1; b_addr = 16'hFFFF; b_wdata = 8'h3C; b_mem_ready = 1'b1;
        applyStimulus(9, 1'b1, 0, 1, 0);
        checkOutput("wr3_wr", wr_v, 16'h007C);
        checkOutput("wr3_doe", doe_v, 16'h00FE);
        checkOutput("wr3_done", done_v, 16'h0080);
        checkOutput("wr3_rd", rd_v, 16'h0000);
        checkOutput("wr3_regs", {b_mem_addr, b_mem_dout}, 32'h00FFFF3C);
        checkOutput("wr3_rdata_kept", b_rdata, 8'hFF);

        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0ABC; b_wdata = 8'h5A;
        @(posedge clock);
        #1;
        b_req = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("rst_pre_strobe", {b_mem_wr, b_mem_doe}, 2'b11);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_async_drop", {b_busy, b_mem_wr, b_mem_doe, b_done}, 4'b0000);
        #1 reset = 1'b0;
        applyStimulus(3, 1'b1, 0, 0, 0);
        checkOutput("rst_no_done", {done_v, busy_v}, 32'h0);

        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0C0D; b_mem_din = 8'h5A; b_mem_ready = 1'b1;
        applyStimulus(9, 1'b1, 0, 1, 0);
        checkOutput("post_rst_done", done_v, 16'h0080);
        checkOutput("post_rst_rd", rd_v, 16'h007C);
        checkOutput("post_rst_berr", berr_v, 16'h0000);
        checkOutput("post_rst_rdata", b_rdata, 8'h5A);
        checkOutput("post_rst_addr", b_mem_addr, 16'h0C0D);

        checkOutput("rd_wr_exclusive", overlap, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
